// File: rtl/monitor_dp_memory_if.sv
// Avalon-MM slave port bundle for one side of the monitor dual-port memory.
// The master drives address/strobes/data; the slave returns read data and its valid pulse.
interface monitor_dp_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/monitor_dp_memory.sv
// Dual-port monitor RAM: s1 (host) and s2 (core) share one array, s1 owns overlapping bytes
// on same-address writes, and each port has a 1- or 2-stage read pipeline with a valid bit.
module monitor_dp_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "monitor_onchip_memory.hex",
  parameter int BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  monitor_dp_memory_if.slave      s1,
  monitor_dp_memory_if.slave      s2,
  output logic [7:0]              collision_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  en;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_WIDTH-1:0]   be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [1:0]            wr_acc;
  logic [1:0]            rd_acc;
  logic                  collide;

  assign en = clken & ~reset_req;

  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;

  // Write wins over read when both strobes are raised on the same port.
  assign wr_acc[0] = en & s1.chipselect & s1.write;
  assign wr_acc[1] = en & s2.chipselect & s2.write;
  assign rd_acc[0] = en & s1.chipselect & s1.read & ~s1.write;
  assign rd_acc[1] = en & s2.chipselect & s2.read & ~s2.write;

  assign collide = wr_acc[0] & wr_acc[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // s2 bytes are written first so the later s1 assignment owns any shared byte.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_acc[1] && be[1][b]) begin
        mem_q[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
      end
    end
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_acc[0] && be[0][b]) begin
        mem_q[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
      end
    end
  end

  logic [7:0]            coll_cnt_d;
  logic [7:0]            coll_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_p0_d [2];
  logic [DATA_WIDTH-1:0] rdata_p0_q [2];
  logic [1:0]            vld_p0_d;
  logic [1:0]            vld_p0_q;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (collide && (coll_cnt_q != 8'hFF)) begin
      coll_cnt_d = coll_cnt_q + 8'd1;
    end
  end

  // Stage 0: synchronous RAM read; the array still holds pre-write data on this edge.
  always_comb begin
    rdata_p0_d = rdata_p0_q;
    vld_p0_d   = vld_p0_q;
    if (en) begin
      vld_p0_d = rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) begin
          rdata_p0_d[p] = mem_q[addr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_cnt_q <= '0;
      vld_p0_q   <= '0;
      for (int p = 0; p < 2; p++) begin
        rdata_p0_q[p] <= '0;
      end
    end else begin
      coll_cnt_q <= coll_cnt_d;
      vld_p0_q   <= vld_p0_d;
      for (int p = 0; p < 2; p++) begin
        rdata_p0_q[p] <= rdata_p0_d[p];
      end
    end
  end

  assign collision_count = coll_cnt_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rdata_p1_d [2];
      logic [DATA_WIDTH-1:0] rdata_p1_q [2];
      logic [1:0]            vld_p1_d;
      logic [1:0]            vld_p1_q;

      // Stage 1: output register, advanced only on enabled edges.
      always_comb begin
        rdata_p1_d = rdata_p1_q;
        vld_p1_d   = vld_p1_q;
        if (en) begin
          vld_p1_d = vld_p0_q;
          for (int p = 0; p < 2; p++) begin
            if (vld_p0_q[p]) begin
              rdata_p1_d[p] = rdata_p0_q[p];
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p1_q <= '0;
          for (int p = 0; p < 2; p++) begin
            rdata_p1_q[p] <= '0;
          end
        end else begin
          vld_p1_q <= vld_p1_d;
          for (int p = 0; p < 2; p++) begin
            rdata_p1_q[p] <= rdata_p1_d[p];
          end
        end
      end

      assign s1.readdata      = rdata_p1_q[0];
      assign s2.readdata      = rdata_p1_q[1];
      assign s1.readdatavalid = vld_p1_q[0];
      assign s2.readdatavalid = vld_p1_q[1];
    end else begin : g_lat1
      assign s1.readdata      = rdata_p0_q[0];
      assign s2.readdata      = rdata_p0_q[1];
      assign s1.readdatavalid = vld_p0_q[0];
      assign s2.readdatavalid = vld_p0_q[1];
    end
  endgenerate

endmodule

// File: doc/monitor_dp_memory.md
# monitor_dp_memory

Parametrised dual-port on-chip memory for the monitor subsystem: two Avalon-MM slave ports, `s1` for the monitor/host side and `s2` for the TinyMIPS core side, sharing one clock and one RAM array. It generalises the single-port monitor memory in three ways:
- configurable data width, depth and read latency;
- explicit `readdatavalid` pipelining;
- deterministic same-cycle write-collision resolution, with a saturating collision counter for debug.

RAM contents are preloaded from `INIT_FILE` and are not cleared by reset.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 11: word-address width; depth = 2^`ADDR_WIDTH`.
- `READ_LATENCY`, 1: either 1 or 2; 2 adds an output register stage.
- `INIT_FILE`, "monitor_onchip_memory.hex": initial contents.
- `BE_WIDTH`, `DATA_WIDTH`/8: derived; byteenable width.

Ports (x = 1 or 2, one set per slave):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  global clock enable.
- `reset_req`  in  1  when high, suppresses all RAM accesses (effective enable = `clken & ~reset_req`).
- `sx_address`  in  `ADDR_WIDTH`  word address.
- `sx_chipselect`  in  1  port select.
- `sx_read`  in  1  read strobe.
- `sx_write`  in  1  write strobe.
- `sx_byteenable`  in  `BE_WIDTH`  per-byte write enable.
- `sx_writedata`  in  `DATA_WIDTH`  write data.
- `sx_readdata`  out  `DATA_WIDTH`  read data.
- `sx_readdatavalid`  out  1  read data valid, one pulse per accepted read.
- `collision_count`  out  8  saturating count of byte-overlapping same-address dual writes.

## Operation
- **Enable.** `en = clken & ~reset_req`. With `en` low, no reads or writes are accepted, and the read pipelines and all output registers hold their state.
- **Accepts.** Per port, a write is accepted when `en & sx_chipselect & sx_write`. A read is accepted when `en & sx_chipselect & sx_read & ~sx_write`; write wins if both strobes are high.
- **Writes.** Only bytes with `sx_byteenable` high are updated.
- **Same-port read-during-write.** Not possible, since write wins.
- **Mixed-port read-during-write** (one port reads the address the other port writes in the same cycle): the read returns the OLD data.
- **Write collision** (both ports write the same address in the same cycle):
  - `s1` wins every byte it enables.
  - `s2` bytes not enabled by `s1` are still written.
  - If any byte is enabled by both ports, `collision_count` increments by 1, saturating at 255.
- **Read pipeline** per port:
  - Stage 0: RAM synchronous read.
  - Stage 1, only when `READ_LATENCY`=2: an output register.
  - The valid bit travels alongside the data.
- **Reset.** While `reset_n` is low, all valid bits clear asynchronously. Any reads in flight are discarded; no `readdatavalid` is produced for them after reset releases.

## Timing
- **Reset values.** `sx_readdata` = 0, `sx_readdatavalid` = 0, `collision_count` = 0.
- **Read latency.** A read accepted at edge N produces `sx_readdata` valid and `sx_readdatavalid`=1 during the cycle after edge N+`READ_LATENCY`-1. That is, data appears one cycle after the accepting edge for latency 1, and two cycles after it for latency 2.
- **Valid pulse.** `sx_readdatavalid` is asserted for exactly one enabled cycle per accepted read. If `en` drops while valid is high, `readdatavalid` and `readdata` hold until the next enabled edge, which clears or advances them. Masters must sample only on enabled cycles.
- **Throughput.** Fully pipelined: one read or write per port per enabled cycle, with no wait states (`waitrequest` is not provided).
- **Write visibility.** A write at edge N is visible to any read accepted at edge N+1 or later.
- **Collision counter.** Updates on the same edge as the colliding write.
- **Address range.** Addresses are word-granular with no wrap logic; the full `ADDR_WIDTH` range is valid.

## Test plan
- **Reset then idle.** Assert `reset_n`=0 mid-way through a latency-2 read → `s1_readdatavalid` stays 0 after release; outputs are 0 and `collision_count`=0.
- **Basic write/read with byteenable.** On `s1`, write 0xDEADBEEF to addr 0x010 with be=4'b1111, then write 0x000000AA with be=4'b0001. Read back on `s2` → 0xDEADBEAA with valid 1 cycle (latency 1) or 2 cycles (latency 2) after the read edge.
- **Mixed-port read-during-write.** Addr 0x020 holds 0x11111111. In the same cycle, `s1` writes 0x22222222 and `s2` reads 0x020 → `s2` gets 0x11111111; the next `s2` read gets 0x22222222.
- **Collision.** Both ports write addr 0x7FF in the same cycle: `s1` 0xAAAAAAAA with be=4'b0011, `s2` 0x55555555 with be=4'b0110 → memory = 0xxx55AAAA, where the top byte is unchanged; `collision_count`=1. Repeat 300 times → count saturates at 255.
- **Enable gating.** Hold `reset_req`=1 while `s1` writes 0x12345678 to 0x030 → contents unchanged. With `clken`=0 during a pending latency-2 read → valid is delayed until `clken` returns; exactly one valid pulse results.
- **Back-to-back streaming.** 16 consecutive `s2` reads at addresses 0..15 → 16 consecutive valid pulses with data in address order, no gaps.
